id_ex_hazard_reg: RTL and testbench

ID/EX pipeline register for the 5-stage RV32I core, with hazard detection and registered forwarding-select generation. Captures decoded operands and control from the decode stage each cycle, computes `forward_select_A`/`forward_select_B` one cycle early by comparing decode source registers against the instructions about to occupy MEM and WB, and inserts bubbles on flush or load-use hazard. Its outputs drive the execution stage directly.

---
 rtl/id_ex_hazard_reg.sv | 158 +++++++++++++++
 tb/tb_id_ex_hazard_reg.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_reg.sv
// ============================================================================
// Module   : id_ex_hazard_reg
// Function : ID/EX pipeline register for the RV32I core. It registers the
//            operand-forwarding selects one cycle early and inserts a bubble
//            on flush or on a load-use hazard.
// Option   : LOAD_USE_STALL_EN enables load-use hazard stalling.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_hazard_reg #(
    parameter logic [6:0] LOAD_OPCODE = 7'b0000011
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        id_valid,
    input  logic [31:0] id_PC,
    input  logic [31:0] id_Rdata1,
    input  logic [31:0] id_Rdata2,
    input  logic [31:0] id_imm32,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [6:0]  id_opcode,
    input  logic [1:0]  id_op_A_sel,
    input  logic        id_op_B_sel,
    input  logic [5:0]  id_ALU_Control,
    input  logic        id_reg_write,
    input  logic        mem_valid,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    output logic        ex_valid,
    output logic [31:0] PC,
    output logic [31:0] Rdata1,
    output logic [31:0] Rdata2,
    output logic [31:0] imm32,
    output logic [1:0]  op_A_sel,
    output logic        op_B_sel,
    output logic [5:0]  ALU_Control,
    output logic [4:0]  ex_rd,
    output logic [6:0]  ex_opcode,
    output logic        ex_reg_write,
    output logic [1:0]  forward_select_A,
    output logic [1:0]  forward_select_B,
    output logic        stall_id
);

`ifdef LOAD_USE_STALL_EN
    localparam logic c_load_use_en = 1'b1;
`else
    localparam logic c_load_use_en = 1'b0;
`endif

    localparam logic [1:0] c_fwd_none = 2'b00;
    localparam logic [1:0] c_fwd_mem  = 2'b10;
    localparam logic [1:0] c_fwd_wb   = 2'b01;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_rdata1;
    logic [31:0] r_rdata2;
    logic [31:0] r_imm32;
    logic [1:0]  r_op_a_sel;
    logic        r_op_b_sel;
    logic [5:0]  r_alu_control;
    logic [4:0]  r_rd;
    logic [6:0]  r_opcode;
    logic        r_reg_write;
    logic [1:0]  r_fwd_a;
    logic [1:0]  r_fwd_b;

    logic        w_use_a;
    logic        w_use_b;
    logic        w_ex_match_a;
    logic        w_ex_match_b;
    logic        w_mem_match_a;
    logic        w_mem_match_b;
    logic [1:0]  w_fwd_a;
    logic [1:0]  w_fwd_b;
    logic        w_load_use;
    logic        w_hazard;
    logic        w_bubble;

    function automatic logic f_match(input logic [4:0] r, input logic [4:0] rd,
                                     input logic wr, input logic v);
        return v & wr & (rd != 5'd0) & (rd == r);
    endfunction

    assign w_use_a = (id_op_A_sel == 2'b00);
    assign w_use_b = ~id_op_B_sel;

    assign w_ex_match_a  = w_use_a & f_match(id_rs1, r_rd, r_reg_write, r_valid);
    assign w_ex_match_b  = w_use_b & f_match(id_rs2, r_rd, r_reg_write, r_valid);
    assign w_mem_match_a = w_use_a & f_match(id_rs1, mem_rd, mem_reg_write, mem_valid);
    assign w_mem_match_b = w_use_b & f_match(id_rs2, mem_rd, mem_reg_write, mem_valid);

    // The instruction now in EX is the newest producer, so it wins over MEM.
    assign w_fwd_a = w_ex_match_a ? c_fwd_mem : (w_mem_match_a ? c_fwd_wb : c_fwd_none);
    assign w_fwd_b = w_ex_match_b ? c_fwd_mem : (w_mem_match_b ? c_fwd_wb : c_fwd_none);

    assign w_load_use = r_valid & r_reg_write & (r_opcode == LOAD_OPCODE)
                      & (w_ex_match_a | w_ex_match_b);
    assign w_hazard   = c_load_use_en & w_load_use;
    assign w_bubble   = flush_in | w_hazard | ~id_valid;

    assign stall_id = w_hazard & ~flush_in & ~stall_in & ~reset;

    always_ff @(posedge clock) begin
        if (reset || (!stall_in && w_bubble)) begin
            r_valid       <= 1'b0;
            r_pc          <= 32'd0;
            r_rdata1      <= 32'd0;
            r_rdata2      <= 32'd0;
            r_imm32       <= 32'd0;
            r_op_a_sel    <= 2'b00;
            r_op_b_sel    <= 1'b0;
            r_alu_control <= 6'd0;
            r_rd          <= 5'd0;
            r_opcode      <= 7'd0;
            r_reg_write   <= 1'b0;
            r_fwd_a       <= c_fwd_none;
            r_fwd_b       <= c_fwd_none;
        end else if (!stall_in) begin
            r_valid       <= 1'b1;
            r_pc          <= id_PC;
            r_rdata1      <= id_Rdata1;
            r_rdata2      <= id_Rdata2;
            r_imm32       <= id_imm32;
            r_op_a_sel    <= id_op_A_sel;
            r_op_b_sel    <= id_op_B_sel;
            r_alu_control <= id_ALU_Control;
            r_rd          <= id_rd;
            r_opcode      <= id_opcode;
            r_reg_write   <= id_reg_write;
            r_fwd_a       <= w_fwd_a;
            r_fwd_b       <= w_fwd_b;
        end
    end

    assign ex_valid         = r_valid;
    assign PC               = r_pc;
    assign Rdata1           = r_rdata1;
    assign Rdata2           = r_rdata2;
    assign imm32            = r_imm32;
    assign op_A_sel         = r_op_a_sel;
    assign op_B_sel         = r_op_b_sel;
    assign ALU_Control      = r_alu_control;
    assign ex_rd            = r_rd;
    assign ex_opcode        = r_opcode;
    assign ex_reg_write     = r_reg_write;
    assign forward_select_A = r_fwd_a;
    assign forward_select_B = r_fwd_b;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_hazard_reg.sv
// ============================================================================
// Module   : tb_id_ex_hazard_reg
// Function : Directed self-checking bench for id_ex_hazard_reg. Expectations
//            follow LOAD_USE_STALL_EN when it is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_hazard_reg;

    localparam logic [6:0] c_op_imm   = 7'b0010011;
    localparam logic [6:0] c_op_reg   = 7'b0110011;
    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_lui   = 7'b0110111;
    localparam logic [6:0] c_op_auipc = 7'b0010111;

`ifdef LOAD_USE_STALL_EN
    localparam logic c_stall_exp = 1'b1;
`else
    localparam logic c_stall_exp = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, stall_in, flush_in, id_valid;
    logic [31:0] id_PC, id_Rdata1, id_Rdata2, id_imm32;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [6:0]  id_opcode;
    logic [1:0]  id_op_A_sel;
    logic        id_op_B_sel;
    logic [5:0]  id_ALU_Control;
    logic        id_reg_write;
    logic        mem_valid, mem_reg_write;
    logic [4:0]  mem_rd;
    logic        ex_valid;
    logic [31:0] PC, Rdata1, Rdata2, imm32;
    logic [1:0]  op_A_sel;
    logic        op_B_sel;
    logic [5:0]  ALU_Control;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic        ex_reg_write;
    logic [1:0]  forward_select_A, forward_select_B;
    logic        stall_id;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_hazard_reg u_dut (
        .clock(clock), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .id_valid(id_valid), .id_PC(id_PC), .id_Rdata1(id_Rdata1),
        .id_Rdata2(id_Rdata2), .id_imm32(id_imm32), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_opcode(id_opcode),
        .id_op_A_sel(id_op_A_sel), .id_op_B_sel(id_op_B_sel),
        .id_ALU_Control(id_ALU_Control), .id_reg_write(id_reg_write),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .ex_valid(ex_valid), .PC(PC), .Rdata1(Rdata1), .Rdata2(Rdata2),
        .imm32(imm32), .op_A_sel(op_A_sel), .op_B_sel(op_B_sel),
        .ALU_Control(ALU_Control), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
        .ex_reg_write(ex_reg_write), .forward_select_A(forward_select_A),
        .forward_select_B(forward_select_B), .stall_id(stall_id)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] imm,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [6:0] op, input logic [1:0] asel, input logic bsel,
                          input logic [5:0] alu, input logic wr);
        id_valid = v; id_PC = pc; id_Rdata1 = r1; id_Rdata2 = r2; id_imm32 = imm;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_opcode = op;
        id_op_A_sel = asel; id_op_B_sel = bsel; id_ALU_Control = alu; id_reg_write = wr;
    endtask

    task automatic set_mem(input logic v, input logic wr, input logic [4:0] rd);
        mem_valid = v; mem_reg_write = wr; mem_rd = rd;
    endtask

    initial begin
        reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
        set_mem(0, 0, 0);
        // addi x5,x0,1 presented while reset is held
        set_id(1, 32'h100, 32'h11, 32'h22, 32'h1, 5'd0, 5'd0, 5'd5, c_op_imm, 2'b00, 1'b1, 6'h00, 1'b1);
        tick(); #1;
        check("rst_stall_id", stall_id, 0);
        tick();
        check("rst_valid", ex_valid, 0);
        check("rst_pc", PC, 0);
        check("rst_rdata1", Rdata1, 0);
        check("rst_rd", ex_rd, 0);
        check("rst_fwdA", forward_select_A, 0);
        check("rst_stall_id2", stall_id, 0);

        reset = 1'b0;
        tick();
        check("addi_valid", ex_valid, 1);
        check("addi_pc", PC, 32'h100);
        check("addi_rd", ex_rd, 5);
        check("addi_imm", imm32, 1);
        check("addi_bsel", op_B_sel, 1);
        check("addi_wr", ex_reg_write, 1);
        check("addi_fwdA", forward_select_A, 0);

        // add x6,x5,x5 right behind addi x5
        set_id(1, 32'h104, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd6, c_op_reg, 2'b00, 1'b0, 6'h00, 1'b1);
        tick();
        check("add_fwdA", forward_select_A, 2'b10);
        check("add_fwdB", forward_select_B, 2'b10);
        check("add_rd", ex_rd, 6);
        check("add_pc", PC, 32'h104);

        // addi x5, nop, sub x7,x5,x1
        set_mem(1, 1, 5);
        set_id(1, 32'h108, 32'h0, 32'h0, 32'h2, 5'd0, 5'd0, 5'd5, c_op_imm, 2'b00, 1'b1, 6'h00, 1'b1);
        tick();
        set_mem(1, 1, 6);
        set_id(0, 32'h10C, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 7'd0, 2'b00, 1'b0, 6'h00, 1'b0);
        tick();
        check("nop_valid", ex_valid, 0);
        check("nop_wr", ex_reg_write, 0);
        set_mem(1, 1, 5);
        set_id(1, 32'h110, 32'h33, 32'h55, 32'h0, 5'd5, 5'd1, 5'd7, c_op_reg, 2'b00, 1'b0, 6'h08, 1'b1);
        tick();
        check("sub_fwdA", forward_select_A, 2'b01);
        check("sub_fwdB", forward_select_B, 2'b00);
        check("sub_alu", ALU_Control, 6'h08);
        check("sub_rdata2", Rdata2, 32'h55);

        // lw x8,0(x2) then add x9,x8,x3
        set_mem(0, 0, 0);
        set_id(1, 32'h114, 32'h0, 32'h0, 32'h0, 5'd2, 5'd0, 5'd8, c_op_load, 2'b00, 1'b1, 6'h00, 1'b1);
        tick();
        check("lw_opcode", ex_opcode, c_op_load);
        check("lw_fwdA", forward_select_A, 0);
        set_mem(1, 1, 7);
        set_id(1, 32'h118, 32'h0, 32'h0, 32'h0, 5'd8, 5'd3, 5'd9, c_op_reg, 2'b00, 1'b0, 6'h00, 1'b1);
        #1;
        check("lu_stall_id", stall_id, c_stall_exp);
        tick();
`ifdef LOAD_USE_STALL_EN
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_fwdA", forward_select_A, 0);
        set_mem(1, 1, 8);
        #1;
        check("lu_stall_id_rel", stall_id, 0);
        tick();
        check("lu_add_valid", ex_valid, 1);
        check("lu_add_rd", ex_rd, 9);
        check("lu_add_fwdA", forward_select_A, 2'b01);
        check("lu_add_fwdB", forward_select_B, 2'b00);
        check("lu_add_pc", PC, 32'h118);
`else
        check("lu_add_valid", ex_valid, 1);
        check("lu_add_rd", ex_rd, 9);
        check("lu_add_fwdA", forward_select_A, 2'b10);
        check("lu_add_fwdB", forward_select_B, 2'b00);
`endif

        // lui x0 with an unused rs1 field that matches EX rd
        set_mem(0, 0, 0);
        set_id(1, 32'h11C, 32'h0, 32'h0, 32'h1000, 5'd9, 5'd9, 5'd0, c_op_lui, 2'b10, 1'b1, 6'h3F, 1'b1);
        tick();
        check("lui_fwdA", forward_select_A, 0);
        check("lui_asel", op_A_sel, 2'b10);
        check("lui_rd", ex_rd, 0);
        // add x10,x0,x0 behind writers of x0
        set_mem(1, 1, 0);
        set_id(1, 32'h120, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd10, c_op_reg, 2'b00, 1'b0, 6'h00, 1'b1);
        tick();
        check("x0_fwdA", forward_select_A, 0);
        check("x0_fwdB", forward_select_B, 0);
        // auipc x11 whose rs fields match both producers
        set_mem(1, 1, 10);
        set_id(1, 32'h124, 32'h0, 32'h0, 32'h2000, 5'd10, 5'd10, 5'd11, c_op_auipc, 2'b01, 1'b1, 6'h00, 1'b1);
        tick();
        check("auipc_fwdA", forward_select_A, 0);
        check("auipc_fwdB", forward_select_B, 0);
        check("auipc_asel", op_A_sel, 2'b01);

        // flush coinciding with a load-use hazard
        set_mem(0, 0, 0);
        set_id(1, 32'h200, 32'h0, 32'h0, 32'h0, 5'd2, 5'd0, 5'd12, c_op_load, 2'b00, 1'b1, 6'h00, 1'b1);
        tick();
        check("lw12_valid", ex_valid, 1);
        set_id(1, 32'h204, 32'h0, 32'h0, 32'h0, 5'd12, 5'd12, 5'd13, c_op_reg, 2'b00, 1'b0, 6'h00, 1'b1);
        flush_in = 1'b1;
        #1;
        check("flush_stall_id", stall_id, 0);
        tick();
        check("flush_valid", ex_valid, 0);
        check("flush_pc", PC, 0);
        check("flush_fwdA", forward_select_A, 0);
        flush_in = 1'b0;

        // external stall for three cycles with a pending load-use
        set_id(1, 32'h300, 32'hDEADBEEF, 32'h0, 32'h0, 5'd2, 5'd0, 5'd14, c_op_load, 2'b00, 1'b1, 6'h00, 1'b1);
        tick();
        check("lw14_rdata1", Rdata1, 32'hDEADBEEF);
        stall_in = 1'b1;
        set_id(1, 32'h304, 32'h0, 32'h0, 32'h0, 5'd14, 5'd14, 5'd15, c_op_reg, 2'b00, 1'b0, 6'h00, 1'b1);
        #1;
        check("stall_stall_id", stall_id, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", PC, 32'h300);
            check("stall_rdata1", Rdata1, 32'hDEADBEEF);
            check("stall_rd", ex_rd, 14);
            check("stall_valid", ex_valid, 1);
        end
        stall_in = 1'b0;
        #1;
        check("unstall_stall_id", stall_id, c_stall_exp);

        // reset during a stall
        stall_in = 1'b1;
        reset = 1'b1;
        #1;
        check("rststall_stall_id", stall_id, 0);
        tick();
        check("rststall_valid", ex_valid, 0);
        check("rststall_pc", PC, 0);
        check("rststall_opcode", ex_opcode, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
